mem_req_sched: RTL and testbench

Shares one Convey memory-controller request port among NR processing cores of the PDES engine. Grants are round-robin, and a requester may lock the port for a multi-beat burst. Each core's outstanding reads are capped by a counter. Returning responses are steered back to the owning core by the core ID embedded in the return-control field. It sits between the event-processing cores and the MC interface, beside the event-queue arbiter.

---
 rtl/mem_req_sched.sv | 166 ++++++++++++++++
 tb/tb_mem_req_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_sched.sv
// Round-robin scheduler sharing one MC request port among NR cores, with burst lock,
// per-core read-outstanding caps and response steering. Optional MEMSCHED_PERF_EN adds perf counters.
module mem_req_sched #(
  parameter int NR     = 4,
  parameter int AW     = 48,
  parameter int DW     = 64,
  parameter int TW     = 8,
  parameter int MAXOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR-1:0]    req_vld,
  input  logic [NR-1:0]    req_lock,
  input  logic [NR*3-1:0]  req_cmd,
  input  logic [NR*AW-1:0] req_addr,
  input  logic [NR*DW-1:0] req_data,
  input  logic [NR*TW-1:0] req_tid,
  output logic [NR-1:0]    req_rdy,
  output logic             mc_req_vld,
  output logic [2:0]       mc_req_cmd,
  output logic [AW-1:0]    mc_req_addr,
  output logic [DW-1:0]    mc_req_data,
  output logic [31:0]      mc_req_rtnctl,
  input  logic             mc_req_stall,
  input  logic             mc_rsp_push,
  input  logic [31:0]      mc_rsp_rtnctl,
  input  logic [DW-1:0]    mc_rsp_data,
  output logic [NR-1:0]    rsp_vld,
  output logic [TW-1:0]    rsp_tid,
  output logic [DW-1:0]    rsp_data
`ifdef MEMSCHED_PERF_EN
  ,
  output logic [NR*32-1:0] perf_gnt_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam int         IW     = $clog2(NR);
  localparam logic [2:0] CMD_RD = 3'd1;

  logic [IW-1:0] rr_ptr, lock_id, gnt_id, rsp_core;
  logic          lock_vld, gnt_vld, slot_free, accept;
  logic [NR-1:0] elig, cnt_inc, cnt_dec, cnt_zero;
  logic [7:0]    out_cnt [NR];
  logic [2:0]    sel_cmd;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [TW-1:0] sel_tid;
  logic          unused_rtnctl;

  assign unused_rtnctl = ^mc_rsp_rtnctl[31:TW+IW];
  assign rsp_core      = mc_rsp_rtnctl[TW +: IW];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      elig[i]     = req_vld[i] & ~((req_cmd[i*3 +: 3] == CMD_RD) & (out_cnt[i] == 8'(MAXOUT)));
      cnt_zero[i] = (out_cnt[i] == 8'd0);
    end
  end

  // A held lock pins the grant to lock_id even when that core is read-blocked.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (lock_vld && req_vld[lock_id]) begin
      gnt_vld = elig[lock_id];
      gnt_id  = lock_id;
    end else begin
      for (int k = NR - 1; k >= 0; k--) begin
        if (elig[rr_ptr + IW'(k)]) begin
          gnt_vld = 1'b1;
          gnt_id  = rr_ptr + IW'(k);
        end
      end
    end
  end

  // Handshake: a core's beat transfers in the cycle req_vld[i] & req_rdy[i]; the MC
  // takes mc_req_vld in any cycle mc_req_stall is low, otherwise the register holds.
  assign slot_free = ~mc_req_vld | ~mc_req_stall;
  assign accept    = slot_free & gnt_vld;
  assign req_rdy   = accept ? ({{(NR-1){1'b0}}, 1'b1} << gnt_id) : '0;

  assign sel_cmd  = req_cmd[int'(gnt_id)*3 +: 3];
  assign sel_addr = req_addr[int'(gnt_id)*AW +: AW];
  assign sel_data = req_data[int'(gnt_id)*DW +: DW];
  assign sel_tid  = req_tid[int'(gnt_id)*TW +: TW];

  always_ff @(posedge clk) begin
    if (reset) begin
      mc_req_vld    <= 1'b0;
      mc_req_cmd    <= '0;
      mc_req_addr   <= '0;
      mc_req_data   <= '0;
      mc_req_rtnctl <= '0;
      rr_ptr        <= '0;
      lock_vld      <= 1'b0;
      lock_id       <= '0;
    end else if (accept) begin
      mc_req_vld    <= 1'b1;
      mc_req_cmd    <= sel_cmd;
      mc_req_addr   <= sel_addr;
      mc_req_data   <= sel_data;
      mc_req_rtnctl <= 32'({gnt_id, sel_tid});
      rr_ptr        <= gnt_id + IW'(1);
      lock_vld      <= req_lock[gnt_id];
      lock_id       <= gnt_id;
    end else if (slot_free) begin
      mc_req_vld <= 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      cnt_inc[i] = accept & (gnt_id == IW'(i)) & (sel_cmd == CMD_RD);
      cnt_dec[i] = mc_rsp_push & (rsp_core == IW'(i));
    end
  end

  // Simultaneous increment and decrement cancel; a decrement at zero saturates.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (reset)
        out_cnt[i] <= 8'd0;
      else if (cnt_inc[i] && !cnt_dec[i])
        out_cnt[i] <= out_cnt[i] + 8'd1;
      else if (cnt_dec[i] && !cnt_inc[i] && !cnt_zero[i])
        out_cnt[i] <= out_cnt[i] - 8'd1;
    end
  end

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (cnt_dec & ~cnt_inc & cnt_zero) == '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld  <= '0;
      rsp_tid  <= '0;
      rsp_data <= '0;
    end else begin
      rsp_vld <= mc_rsp_push ? ({{(NR-1){1'b0}}, 1'b1} << rsp_core) : '0;
      if (mc_rsp_push) begin
        rsp_tid  <= mc_rsp_rtnctl[TW-1:0];
        rsp_data <= mc_rsp_data;
      end
    end
  end

`ifdef MEMSCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_gnt_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NR; i++)
        if (accept && gnt_id == IW'(i))
          perf_gnt_cnt[i*32 +: 32] <= perf_gnt_cnt[i*32 +: 32] + 32'd1;
      if (mc_req_vld && mc_req_stall)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed bench for mem_req_sched: a rule-level model checked every cycle plus literal expectations.
module tb_mem_req_sched;
  localparam int NR = 4, AW = 48, DW = 64, TW = 8, MAXOUT = 15;
  localparam logic [2:0] RD = 3'd1, WR = 3'd2;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0]    req_vld, req_lock, req_rdy;
  logic [NR*3-1:0]  req_cmd;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR*TW-1:0] req_tid;
  logic             mc_req_vld, mc_req_stall, mc_rsp_push;
  logic [2:0]       mc_req_cmd;
  logic [AW-1:0]    mc_req_addr;
  logic [DW-1:0]    mc_req_data, mc_rsp_data, rsp_data;
  logic [31:0]      mc_req_rtnctl, mc_rsp_rtnctl;
  logic [NR-1:0]    rsp_vld;
  logic [TW-1:0]    rsp_tid;
`ifdef MEMSCHED_PERF_EN
  logic [NR*32-1:0] perf_gnt_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  mem_req_sched #(.NR(NR), .AW(AW), .DW(DW), .TW(TW), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .reset(reset),
    .req_vld(req_vld), .req_lock(req_lock), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data(req_data), .req_tid(req_tid), .req_rdy(req_rdy),
    .mc_req_vld(mc_req_vld), .mc_req_cmd(mc_req_cmd), .mc_req_addr(mc_req_addr),
    .mc_req_data(mc_req_data), .mc_req_rtnctl(mc_req_rtnctl), .mc_req_stall(mc_req_stall),
    .mc_rsp_push(mc_rsp_push), .mc_rsp_rtnctl(mc_rsp_rtnctl), .mc_rsp_data(mc_rsp_data),
    .rsp_vld(rsp_vld), .rsp_tid(rsp_tid), .rsp_data(rsp_data)
`ifdef MEMSCHED_PERF_EN
    , .perf_gnt_cnt(perf_gnt_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model state: what each registered output must hold
  bit            m_valid = 0;
  bit            e_vld = 0;
  logic [2:0]    e_cmd = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  logic [31:0]   e_rtn = '0;
  logic [NR-1:0] e_rsp_vld = '0;
  logic [TW-1:0] e_rsp_tid = '0;
  logic [DW-1:0] e_rsp_data = '0;
  logic [NR-1:0] exp_rdy;
  int m_rr = 0, m_lock_id = 0, m_stall = 0;
  bit m_lock = 0;
  int m_cnt[NR];
  int m_gnt[NR];
  int g, rc;
  bit slot;
  logic [1:0] gnt_q[$];

  function automatic bit eligible(input int c);
    return req_vld[c] && !(req_cmd[c*3 +: 3] == RD && m_cnt[c] == MAXOUT);
  endfunction

  function automatic int pick();
    int r = -1;
    if (m_lock && req_vld[m_lock_id]) begin
      if (eligible(m_lock_id)) r = m_lock_id;
    end else begin
      for (int k = 0; k < NR; k++)
        if (r < 0 && eligible((m_rr + k) % NR)) r = (m_rr + k) % NR;
    end
    return r;
  endfunction

  // compare process: check, then advance the model across the coming posedge
  always @(negedge clk) begin
    g = pick();
    slot = !e_vld || !mc_req_stall;
    exp_rdy = '0;
    if (slot && g >= 0) exp_rdy[g] = 1'b1;
    if (m_valid) begin
      chk("mc_req_vld", 64'(mc_req_vld), 64'(e_vld));
      if (e_vld) begin
        chk("mc_req_cmd", 64'(mc_req_cmd), 64'(e_cmd));
        chk("mc_req_addr", 64'(mc_req_addr), 64'(e_addr));
        chk("mc_req_data", mc_req_data, e_data);
        chk("mc_req_rtnctl", 64'(mc_req_rtnctl), 64'(e_rtn));
      end
      chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      chk("rsp_vld", 64'(rsp_vld), 64'(e_rsp_vld));
      if (e_rsp_vld != 0) begin
        chk("rsp_tid", 64'(rsp_tid), 64'(e_rsp_tid));
        chk("rsp_data", rsp_data, e_rsp_data);
      end
    end
    if (reset) begin
      m_valid = 1; e_vld = 0; e_cmd = '0; e_addr = '0; e_data = '0; e_rtn = '0;
      e_rsp_vld = '0; e_rsp_tid = '0; e_rsp_data = '0;
      m_rr = 0; m_lock = 0; m_lock_id = 0; m_stall = 0;
      for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; m_gnt[i] = 0; end
    end else if (m_valid) begin
      if (e_vld && mc_req_stall) m_stall++;
      if (slot && g >= 0) begin
        e_vld  = 1;
        e_cmd  = req_cmd[g*3 +: 3];
        e_addr = req_addr[g*AW +: AW];
        e_data = req_data[g*DW +: DW];
        e_rtn  = 32'(g << TW) | 32'(req_tid[g*TW +: TW]);
        m_rr = (g + 1) % NR;
        m_lock = req_lock[g];
        m_lock_id = g;
        m_gnt[g]++;
        if (e_cmd == RD) m_cnt[g]++;
        gnt_q.push_back(2'(g));
      end else if (slot) begin
        e_vld = 0;
      end
      e_rsp_vld = '0;
      if (mc_rsp_push) begin
        rc = int'(mc_rsp_rtnctl[TW +: 2]);
        if (m_cnt[rc] > 0) m_cnt[rc]--;
        e_rsp_vld[rc] = 1'b1;
        e_rsp_tid = mc_rsp_rtnctl[TW-1:0];
        e_rsp_data = mc_rsp_data;
      end
    end
  end

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic set_req(input int c, input bit v, input bit lk, input logic [2:0] cmd,
                         input logic [AW-1:0] a, input logic [TW-1:0] t);
    req_vld[c] = v;
    req_lock[c] = lk;
    req_cmd[c*3 +: 3] = cmd;
    req_addr[c*AW +: AW] = a;
    req_data[c*DW +: DW] = 64'hDA7A_0000_0000_0000 | 64'(a);
    req_tid[c*TW +: TW] = t;
  endtask

  task automatic clear_reqs();
    req_vld = '0;
    req_lock = '0;
  endtask

  task automatic push_rsp(input int c, input logic [TW-1:0] t);
    mc_rsp_push = 1'b1;
    mc_rsp_rtnctl = 32'(c << TW) | 32'(t);
    mc_rsp_data = 64'h5555_0000_0000_0000 | 64'(c * 1000 + int'(t));
  endtask

  initial begin
    reset = 1'b1;
    req_vld = '0; req_lock = '0; req_cmd = '0; req_addr = '0; req_data = '0; req_tid = '0;
    mc_req_stall = 1'b0; mc_rsp_push = 1'b0; mc_rsp_rtnctl = '0; mc_rsp_data = '0;
    step(2);
    reset = 1'b0;
    chk("rst_mc_vld", 64'(mc_req_vld), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_rtnctl", 64'(mc_req_rtnctl), 64'd0);
    chk("rst_rdy", 64'(req_rdy), 64'd0);

    // all four cores stream reads: strict rotation, one per cycle
    for (int c = 0; c < NR; c++) set_req(c, 1, 0, RD, 48'h1000 * (c + 1), 8'(8'h10 + c));
    gnt_q.delete();
    step(8);
    clear_reqs();
    chk("rr_count", 64'(gnt_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("rr_order", 64'(gnt_q[i]), 64'(i % 4));
    chk("rr_rtn_core", 64'(mc_req_rtnctl[9:8]), 64'd3);
    chk("rr_rtn_tid", 64'(mc_req_rtnctl[7:0]), 64'h13);
    for (int i = 0; i < 8; i++) begin push_rsp(i % 4, 8'(8'h10 + i % 4)); step(); end
    mc_rsp_push = 1'b0;

    // core 1 locks a 3-beat burst while cores 0 and 2 wait
    gnt_q.delete();
    set_req(1, 1, 1, WR, 48'h2100, 8'h21);
    step();
    set_req(0, 1, 0, WR, 48'h2000, 8'h20);
    set_req(2, 1, 0, WR, 48'h2200, 8'h22);
    step();
    req_lock[1] = 1'b0;
    step();
    req_vld[1] = 1'b0;
    step(2);
    clear_reqs();
    chk("lock_count", 64'(gnt_q.size()), 64'd5);
    chk("lock_b0", 64'(gnt_q[0]), 64'd1);
    chk("lock_b1", 64'(gnt_q[1]), 64'd1);
    chk("lock_b2", 64'(gnt_q[2]), 64'd1);
    chk("lock_next", 64'(gnt_q[3]), 64'd2);
    chk("lock_then", 64'(gnt_q[4]), 64'd0);

    // core 0 fills its outstanding budget; core 3 keeps flowing
    gnt_q.delete();
    set_req(0, 1, 0, RD, 48'h3000, 8'h30);
    step(15);
    set_req(3, 1, 0, WR, 48'h3300, 8'h33);
    #1 chk("limit_rdy", 64'(req_rdy), 64'b1000);
    step(2);
    push_rsp(0, 8'h30);
    #1 chk("limit_rdy_push", 64'(req_rdy), 64'b1000);
    step();
    mc_rsp_push = 1'b0;
    #1 chk("limit_release_rdy", 64'(req_rdy), 64'b0001);
    step();
    clear_reqs();
    chk("limit_count", 64'(gnt_q.size()), 64'd19);
    chk("limit_core3", 64'(gnt_q[15]), 64'd3);
    chk("limit_16th", 64'(gnt_q[18]), 64'd0);
    for (int i = 0; i < 15; i++) begin push_rsp(0, 8'h30); step(); end
    mc_rsp_push = 1'b0;

    // MC stall holds the registered request for 5 cycles
    gnt_q.delete();
    set_req(2, 1, 0, RD, 48'hABC, 8'h22);
    step();
    mc_req_stall = 1'b1;
    clear_reqs();
    set_req(1, 1, 0, RD, 48'hBBB, 8'h11);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_vld", 64'(mc_req_vld), 64'd1);
      chk("stall_addr", 64'(mc_req_addr), 64'hABC);
      chk("stall_rdy", 64'(req_rdy), 64'd0);
      step();
    end
    mc_req_stall = 1'b0;
    #1 chk("stall_release_rdy", 64'(req_rdy), 64'b0010);
    step();
    clear_reqs();
    chk("stall_next_addr", 64'(mc_req_addr), 64'hBBB);
    chk("stall_next_core", 64'(mc_req_rtnctl[9:8]), 64'd1);
    step();
    chk("stall_drain_vld", 64'(mc_req_vld), 64'd0);
    chk("stall_once", 64'(gnt_q.size()), 64'd2);

    // response to core 2 in the same cycle core 2 issues a read
    set_req(2, 1, 0, RD, 48'hC0C0, 8'h33);
    mc_rsp_push = 1'b1;
    mc_rsp_rtnctl = 32'h2A5;
    mc_rsp_data = 64'hFEED;
    #1 chk("same_cyc_rdy", 64'(req_rdy), 64'b0100);
    step();
    mc_rsp_push = 1'b0;
    clear_reqs();
    chk("same_cyc_rsp_vld", 64'(rsp_vld), 64'b0100);
    chk("same_cyc_rsp_tid", 64'(rsp_tid), 64'hA5);
    chk("same_cyc_rsp_data", rsp_data, 64'hFEED);
    step();
    chk("rsp_vld_drop", 64'(rsp_vld), 64'd0);
    push_rsp(1, 8'h11); step();
    push_rsp(2, 8'h33); step();
    mc_rsp_push = 1'b0;

    // reset in the middle of a locked read burst
    set_req(3, 1, 1, RD, 48'hD00D, 8'h44);
    step(2);
    reset = 1'b1;
    clear_reqs();
    step();
    chk("mid_rst_mc_vld", 64'(mc_req_vld), 64'd0);
    chk("mid_rst_addr", 64'(mc_req_addr), 64'd0);
    chk("mid_rst_data", mc_req_data, 64'd0);
    chk("mid_rst_rtnctl", 64'(mc_req_rtnctl), 64'd0);
    chk("mid_rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("mid_rst_rsp_tid", 64'(rsp_tid), 64'd0);
    chk("mid_rst_rdy", 64'(req_rdy), 64'd0);
    reset = 1'b0;
    gnt_q.delete();
    for (int c = 0; c < NR; c++) set_req(c, 1, 0, WR, 48'h5000 + 48'(c), 8'(8'h50 + c));
    step(2);
    clear_reqs();
    chk("post_rst_first", 64'(gnt_q[0]), 64'd0);
    chk("post_rst_second", 64'(gnt_q[1]), 64'd1);
    step(2);

`ifdef MEMSCHED_PERF_EN
    for (int i = 0; i < NR; i++)
      chk("perf_gnt", 64'(perf_gnt_cnt[i*32 +: 32]), 64'(m_gnt[i]));
    chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
